piano_key_renderer: RTL

Parametrised piano keyboard renderer and key-state tracker for the VGA path. It consumes the pixel column/row from `crvga` and scan codes from `keyboard`. It draws an N-octave keyboard with per-key highlight, and returns 3-bit colour to `crvga`. It succeeds the single-octave, single-key drawer: it covers every key, handles make/break codes and has a movable base octave.

---
 rtl/piano_key_renderer_pkg.sv | 75 +++++++
 rtl/piano_key_renderer_if.sv | 17 +
 rtl/piano_scan_decoder.sv | 76 +++++++
 rtl/piano_key_renderer.sv | 107 ++++++++++
 4 files changed

// File: rtl/piano_key_renderer_pkg.sv
// Shared definitions for the piano keyboard renderer: colours, PS/2 set-2
// scan codes, decoder states and small key-geometry helpers.
package piano_key_renderer_pkg;

    // {R,G,B} colours returned to the VGA path
    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_BLUE   = 3'b001;
    localparam logic [2:0] COLOR_RED    = 3'b100;
    localparam logic [2:0] COLOR_YELLOW = 3'b110;
    localparam logic [2:0] COLOR_WHITE  = 3'b111;

    // Prefix and octave-shift codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;

    // Note codes, C..B
    localparam logic [7:0] SC_C  = 8'h1C, SC_CS = 8'h1D, SC_D  = 8'h1B, SC_DS = 8'h24;
    localparam logic [7:0] SC_E  = 8'h23, SC_F  = 8'h2B, SC_FS = 8'h2C, SC_G  = 8'h34;
    localparam logic [7:0] SC_GS = 8'h35, SC_A  = 8'h33, SC_AS = 8'h3C, SC_B  = 8'h3B;

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} scan_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } note_t;

    // Scan code to note index within an octave
    function automatic note_t note_of(input logic [7:0] code);
        note_t n;
        n.vld = 1'b1;
        n.idx = 4'd0;
        case (code)
            SC_C:    n.idx = 4'd0;
            SC_CS:   n.idx = 4'd1;
            SC_D:    n.idx = 4'd2;
            SC_DS:   n.idx = 4'd3;
            SC_E:    n.idx = 4'd4;
            SC_F:    n.idx = 4'd5;
            SC_FS:   n.idx = 4'd6;
            SC_G:    n.idx = 4'd7;
            SC_GS:   n.idx = 4'd8;
            SC_A:    n.idx = 4'd9;
            SC_AS:   n.idx = 4'd10;
            SC_B:    n.idx = 4'd11;
            default: n.vld = 1'b0;
        endcase
        return n;
    endfunction

    // Note index of white key w (0..6) within an octave
    function automatic logic [3:0] white_note(input logic [2:0] w);
        case (w)
            3'd0:    return 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd5;
            3'd4:    return 4'd7;
            3'd5:    return 4'd9;
            default: return 4'd11;
        endcase
    endfunction

    // E and B have no sharp to their right; C and F have no flat to their left
    function automatic logic has_right(input logic [2:0] w);
        return (w != 3'd2) && (w != 3'd6);
    endfunction

    function automatic logic has_left(input logic [2:0] w);
        return (w != 3'd0) && (w != 3'd3);
    endfunction

endpackage

// File: rtl/piano_key_renderer_if.sv
// Pixel/scan-code inputs and colour/key-state outputs of the piano renderer.
// slave is the renderer side, master is the VGA/keyboard side.
interface piano_key_renderer_if #(parameter int OCTAVES = 2);
    logic                    iPixelEn;
    logic [9:0]              iCurrentCol;
    logic [9:0]              iCurrentRow;
    logic                    iScanValid;
    logic [7:0]              iScanCode;
    logic [2:0]              oColor;
    logic [12*OCTAVES-1:0]   oKeyState;
    logic [1:0]              oOctave;

    modport master (output iPixelEn, iCurrentCol, iCurrentRow, iScanValid, iScanCode,
                    input  oColor, oKeyState, oOctave);
    modport slave  (input  iPixelEn, iCurrentCol, iCurrentRow, iScanValid, iScanCode,
                    output oColor, oKeyState, oOctave);
endinterface

// File: rtl/piano_scan_decoder.sv
// PS/2 set-2 decoder: prefix FSM, note map, base-octave register and key bits.
// PIANO_LATCH_EN: make codes toggle keys and break codes are swallowed.
module piano_scan_decoder
    import piano_key_renderer_pkg::*;
#(
    parameter int OCTAVES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iScanValid,
    input  logic [7:0]            iScanCode,
    output logic [12*OCTAVES-1:0] oKeyState,
    output logic [1:0]            oOctave
);
    localparam logic [1:0] OCT_MAX = 2'(OCTAVES - 1);

    scan_state_t           r_state;
    logic [12*OCTAVES-1:0] r_keys;
    logic [1:0]            r_oct;
    note_t                 w_note;
    logic [11:0]           w_onehot;
    logic [12*OCTAVES-1:0] w_make_mask;
    logic [12*OCTAVES-1:0] w_on_make;
    logic [12*OCTAVES-1:0] w_on_break;

    assign w_note   = note_of(iScanCode);
    assign w_onehot = w_note.vld ? (12'd1 << w_note.idx) : 12'd0;

    // A make only touches the note within the current base octave
    always_comb begin
        w_make_mask = '0;
        for (int o = 0; o < OCTAVES; o++)
            if (2'(o) == r_oct) w_make_mask[o*12 +: 12] = w_onehot;
    end

`ifdef PIANO_LATCH_EN
    assign w_on_make  = r_keys ^ w_make_mask;
    assign w_on_break = r_keys;
`else
    // Break clears the note in every octave so an octave shift cannot strand a key
    assign w_on_make  = r_keys | w_make_mask;
    assign w_on_break = r_keys & ~{OCTAVES{w_onehot}};
`endif

    // Prefix FSM with registered key state and octave
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_keys  <= '0;
            r_oct   <= '0;
        end else if (iScanValid) begin
            case (r_state)
                S_IDLE: begin
                    if (iScanCode == SC_BREAK)      r_state <= S_BREAK;
                    else if (iScanCode == SC_EXT)   r_state <= S_EXT;
                    else if (w_note.vld)            r_keys  <= w_on_make;
                    else if (iScanCode == SC_OCT_DN) begin
                        if (r_oct != 2'd0) r_oct <= r_oct - 2'd1;
                    end else if (iScanCode == SC_OCT_UP) begin
                        if (r_oct != OCT_MAX) r_oct <= r_oct + 2'd1;
                    end
                end
                S_BREAK: begin
                    r_keys  <= w_on_break;
                    r_state <= S_IDLE;
                end
                S_EXT:   r_state <= (iScanCode == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oKeyState = r_keys;
    assign oOctave   = r_oct;

endmodule

// File: rtl/piano_key_renderer.sv
// N-octave piano keyboard renderer with per-key highlight for the VGA path.
// Key tracking lives in piano_scan_decoder; PIANO_LATCH_EN selects latched chords.
module piano_key_renderer
    import piano_key_renderer_pkg::*;
#(
    parameter int OCTAVES = 2,
    parameter int X0      = 40,
    parameter int Y0      = 100,
    parameter int WHITE_W = 40,
    parameter int BLACK_W = 24,
    parameter int KEY_H   = 280,
    parameter int BLACK_H = 140
) (
    input  logic                 Clock,
    input  logic                 Reset,
    piano_key_renderer_if.slave  io
);
    localparam logic [4:0] L_NW       = 5'(7 * OCTAVES);
    localparam logic [9:0] L_COL_LOAD = 10'(X0 - 1);
    localparam logic [9:0] L_OFF_LAST = 10'(WHITE_W - 1);
    localparam logic [9:0] L_RB       = 10'(WHITE_W - BLACK_W / 2);
    localparam logic [9:0] L_LB       = 10'(BLACK_W / 2);
    localparam logic [9:0] L_Y0       = 10'(Y0);
    localparam logic [9:0] L_YK       = 10'(Y0 + KEY_H);
    localparam logic [9:0] L_YB       = 10'(Y0 + BLACK_H);

    // r_wpos/r_woct are white_idx mod 7 and div 7, kept alongside to avoid a divider
    logic [4:0]            r_white_idx;
    logic [9:0]            r_offset;
    logic [2:0]            r_wpos;
    logic [2:0]            r_woct;
    logic [2:0]            r_color;
    logic [12*OCTAVES-1:0] w_keys;
    logic [63:0]           w_keys_pad;
    logic                  w_in_kbd, w_right, w_left, w_black, w_pressed;
    logic [3:0]            w_note;
    logic [5:0]            w_key;
    logic [2:0]            w_color;

    piano_scan_decoder #(.OCTAVES(OCTAVES)) u_dec (
        .Clock      (Clock),
        .Reset      (Reset),
        .iScanValid (io.iScanValid),
        .iScanCode  (io.iScanCode),
        .oKeyState  (w_keys),
        .oOctave    (io.oOctave)
    );
    assign io.oKeyState = w_keys;

    // Column position counters; they rest saturated (background) outside the keyboard
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_white_idx <= L_NW;
            r_offset    <= '0;
            r_wpos      <= '0;
            r_woct      <= 3'(OCTAVES);
        end else if (io.iPixelEn) begin
            if (io.iCurrentCol == L_COL_LOAD) begin
                r_white_idx <= '0;
                r_offset    <= '0;
                r_wpos      <= '0;
                r_woct      <= '0;
            end else if (r_white_idx != L_NW) begin
                if (r_offset == L_OFF_LAST) begin
                    r_offset    <= '0;
                    r_white_idx <= r_white_idx + 5'd1;
                    if (r_wpos == 3'd6) begin
                        r_wpos <= '0;
                        r_woct <= r_woct + 3'd1;
                    end else begin
                        r_wpos <= r_wpos + 3'd1;
                    end
                end else begin
                    r_offset <= r_offset + 10'd1;
                end
            end
        end
    end

    // Classify the current pixel; key state is the pre-update register value
    always_comb begin
        w_in_kbd   = (r_white_idx != L_NW) && (io.iCurrentRow >= L_Y0) && (io.iCurrentRow < L_YK);
        w_right    = has_right(r_wpos) && (r_offset >= L_RB);
        w_left     = has_left(r_wpos) && (r_offset < L_LB) && (r_white_idx != 5'd0);
        w_black    = (io.iCurrentRow < L_YB) && (w_right || w_left);
        w_note     = white_note(r_wpos);
        if (w_black) w_note = w_right ? w_note + 4'd1 : w_note - 4'd1;
        w_key      = 6'(r_woct) * 6'd12 + 6'(w_note);
        w_keys_pad = 64'(w_keys);
        w_pressed  = w_keys_pad[w_key];
        w_color    = COLOR_BLUE;
        if (w_in_kbd) begin
            if (w_black)                w_color = w_pressed ? COLOR_RED : COLOR_BLACK;
            else if (r_offset == 10'd0) w_color = COLOR_BLACK;
            else                        w_color = w_pressed ? COLOR_YELLOW : COLOR_WHITE;
        end
    end

    // Colour register, updated only on pixel strobes
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)           r_color <= COLOR_BLACK;
        else if (io.iPixelEn) r_color <= w_color;
    end

    assign io.oColor = r_color;

endmodule
